memory_dumper: RTL and testbench

MEMORY_DUMPER -- requirements
Module: memory_dumper

---
 rtl/dumper_pkg.sv | 32 +++
 rtl/memory_dumper_if.sv | 23 ++
 rtl/word_serializer.sv | 66 ++++++
 rtl/memory_dumper.sv | 143 ++++++++++++++
 tb/tb_memory_dumper.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dumper_pkg.sv
// Shared types and constants for the memory dumper: FSM encoding, word/byte
// geometry and the helper that selects a byte of a word MSB first.
package dumper_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned IDX_W          = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_READ    = 3'd1;
   localparam logic [2:0] ST_SEND    = 3'd2;
   localparam logic [2:0] ST_TRAILER = 3'd3;
   localparam logic [2:0] ST_FIN     = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      READ    = ST_READ,
      SEND    = ST_SEND,
      TRAILER = ST_TRAILER,
      FIN     = ST_FIN
   } state_e;

   // Index 0 selects bits [31:24]; ~idx equals (3 - idx) for a 2-bit index.
   function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                    input logic [IDX_W-1:0]  idx);
      logic [WORD_W-1:0] sh;
      sh = w >> {~idx, 3'b000};
      return BYTE_W'(sh);
   endfunction

endpackage

// File: rtl/memory_dumper_if.sv
// Memory read port and UART byte port of the memory dumper, grouped as one bus.
interface memory_dumper_if;
   import dumper_pkg::*;

   logic [WORD_W-1:0] mem_out_addr;
   logic              mem_out_valid;
   logic [WORD_W-1:0] mem_out_data;
   logic              mem_out_ready;
   logic [BYTE_W-1:0] uart_in_data;
   logic              uart_in_valid;
   logic              uart_in_ready;

   modport master (
      output mem_out_addr, mem_out_valid, uart_in_data, uart_in_valid,
      input  mem_out_data, mem_out_ready, uart_in_ready
   );

   modport slave (
      input  mem_out_addr, mem_out_valid, uart_in_data, uart_in_valid,
      output mem_out_data, mem_out_ready, uart_in_ready
   );

endinterface

// File: rtl/word_serializer.sv
// Sends a loaded 32-bit word as four bytes, MSB first, over a valid/ready
// handshake; used for both data words and the checksum trailer.
module word_serializer
   import dumper_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   output logic [BYTE_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              word_done_c_o
);

   logic [WORD_W-1:0] word_q,  word_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              valid_q, valid_d;
   logic [BYTE_W-1:0] data_q,  data_d;
   logic              accept;
   logic              last_byte;

   always_comb begin
      word_d    = word_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      data_d    = data_q;
      accept    = valid_q && ready_i;
      last_byte = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

      if (load_i) begin
         word_d  = word_i;
         idx_d   = '0;
         valid_d = 1'b1;
         data_d  = word_byte(word_i, IDX_W'(0));
      end else if (accept) begin
         if (last_byte) begin
            idx_d   = '0;
            valid_d = 1'b0;
         end else begin
            // Next byte is ready the cycle after acceptance: no bubble.
            idx_d  = idx_q + IDX_W'(1);
            data_d = word_byte(word_q, idx_q + IDX_W'(1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         word_q  <= word_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign data_o        = data_q;
   assign valid_o       = valid_q;
   assign word_done_c_o = accept && last_byte;

endmodule

// File: rtl/memory_dumper.sv
// Reads word_count words from memory starting at base_addr and streams them
// to a UART byte port MSB first, optionally followed by a 32-bit sum trailer.
module memory_dumper
   import dumper_pkg::*;
#(
   parameter int unsigned COUNT_W     = 16,
   parameter bit          CHECKSUM_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WORD_W-1:0]  base_addr,
   input  logic [COUNT_W-1:0] word_count,
   output logic               busy,
   output logic               done,
   memory_dumper_if.master    bus
);

   state_e             state_q,     state_d;
   logic [WORD_W-1:0]  addr_q,      addr_d;
   logic [COUNT_W-1:0] count_q,     count_d;
   logic [WORD_W-1:0]  csum_q,      csum_d;
   logic               mem_valid_q, mem_valid_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;

   logic               mem_accept;
   logic               ser_load;
   logic [WORD_W-1:0]  ser_word;
   logic [BYTE_W-1:0]  ser_data;
   logic               ser_valid;
   logic               ser_word_done;

   word_serializer u_ser (
      .clk           (clk),
      .rst_n         (reset),
      .load_i        (ser_load),
      .word_i        (ser_word),
      .data_o        (ser_data),
      .valid_o       (ser_valid),
      .ready_i       (bus.uart_in_ready),
      .word_done_c_o (ser_word_done)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      csum_d      = csum_q;
      mem_valid_d = mem_valid_q;
      ser_load    = 1'b0;
      ser_word    = bus.mem_out_data;
      mem_accept  = mem_valid_q && bus.mem_out_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               count_d = word_count;
               csum_d  = '0;
               if (word_count == '0) begin
                  if (CHECKSUM_EN) begin
                     state_d  = TRAILER;
                     ser_load = 1'b1;
                     ser_word = '0;
                  end else begin
                     state_d = FIN;
                  end
               end else begin
                  state_d     = READ;
                  mem_valid_d = 1'b1;
               end
            end
         end
         READ: begin
            if (mem_accept) begin
               csum_d      = csum_q + bus.mem_out_data;
               mem_valid_d = 1'b0;
               ser_load    = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (ser_word_done) begin
               addr_d  = addr_q + WORD_W'(1);
               count_d = count_q - COUNT_W'(1);
               if (count_q != COUNT_W'(1)) begin
                  state_d     = READ;
                  mem_valid_d = 1'b1;
               end else if (CHECKSUM_EN) begin
                  state_d  = TRAILER;
                  ser_load = 1'b1;
                  ser_word = csum_q;
               end else begin
                  state_d = FIN;
               end
            end
         end
         TRAILER: begin
            if (ser_word_done) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d == READ) || (state_d == SEND) || (state_d == TRAILER);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         csum_q      <= '0;
         mem_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         csum_q      <= csum_d;
         mem_valid_q <= mem_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign busy              = busy_q;
   assign done              = done_q;
   assign bus.mem_out_addr  = addr_q;
   assign bus.mem_out_valid = mem_valid_q;
   assign bus.uart_in_data  = ser_data;
   assign bus.uart_in_valid = ser_valid;

endmodule

// File: tb/tb_memory_dumper.sv
// Scoreboard bench for memory_dumper: expected bytes/addresses are queued at
// stimulus time and popped by a negedge monitor as handshakes complete.
module tb_memory_dumper;
   import dumper_pkg::*;

   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [31:0]   base_addr;
   logic [CW-1:0] word_count;
   logic          busy;
   logic          done;

   memory_dumper_if bus ();

   memory_dumper #(.COUNT_W(CW), .CHECKSUM_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h1122_3344;
         32'h0000_0011: return 32'h5566_7788;
         32'h0000_0020: return 32'hCAFE_F00D;
         32'hFFFF_FFFF: return 32'h8000_0001;
         32'h0000_0000: return 32'h8000_000F;
         default:       return a ^ 32'hA5A5_A5A5;
      endcase
   endfunction

   assign bus.mem_out_data = mem_word(bus.mem_out_addr);

   int n_vec = 0;
   int n_err = 0;
   logic [7:0]  exp_bytes[$];
   logic [31:0] exp_addrs[$];

   // Written only by the monitor.
   int cyc = 0;
   int mem_wait = 0;
   int done_cnt = 0;
   int bytes_popped = 0;
   int mem_valid_cycles = 0;
   int mem_stall_cycles = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;
   logic       prev_mem_stall = 1'b0;
   logic [31:0] prev_addr = '0;

   // Written only by the test sequence.
   int   ready_mode = 0;
   int   stop_after = 0;
   int   mem_delay = 0;
   logic monitor_en = 1'b0;

   always @(negedge clk) begin
      cyc++;
      case (ready_mode)
         0:       bus.uart_in_ready = 1'b1;
         1:       bus.uart_in_ready = (cyc % 3 == 0);
         default: bus.uart_in_ready = (bytes_popped < stop_after);
      endcase
      if (bus.mem_out_valid === 1'b1) begin
         mem_wait++;
         bus.mem_out_ready = (mem_wait > mem_delay);
      end else begin
         mem_wait = 0;
         bus.mem_out_ready = 1'b0;
      end

      if (monitor_en) begin
         n_vec++;
         if (bus.mem_out_valid && bus.uart_in_valid) begin
            n_err++;
            $display("FAIL excl: mem_out_valid=%b uart_in_valid=%b, required not both 1", bus.mem_out_valid, bus.uart_in_valid);
         end
         if (prev_stall) begin
            n_vec++;
            if (bus.uart_in_valid !== 1'b1 || bus.uart_in_data !== prev_data) begin
               n_err++;
               $display("FAIL uart_hold: valid=%b data=%h, required 1/%h", bus.uart_in_valid, bus.uart_in_data, prev_data);
            end
         end
         if (prev_mem_stall) begin
            n_vec++;
            if (bus.mem_out_valid !== 1'b1 || bus.mem_out_addr !== prev_addr) begin
               n_err++;
               $display("FAIL mem_hold: valid=%b addr=%h, required 1/%h", bus.mem_out_valid, bus.mem_out_addr, prev_addr);
            end
         end
         if (bus.uart_in_valid && bus.uart_in_ready) begin
            n_vec++;
            bytes_popped++;
            if (exp_bytes.size() == 0) begin
               n_err++;
               $display("FAIL byte: got %h, required none", bus.uart_in_data);
            end else begin
               logic [7:0] e;
               e = exp_bytes.pop_front();
               if (bus.uart_in_data !== e) begin
                  n_err++;
                  $display("FAIL byte: got %h, required %h", bus.uart_in_data, e);
               end
            end
         end
         if (bus.mem_out_valid && bus.mem_out_ready) begin
            n_vec++;
            if (exp_addrs.size() == 0) begin
               n_err++;
               $display("FAIL read_addr: got %h, required none", bus.mem_out_addr);
            end else begin
               logic [31:0] ea;
               ea = exp_addrs.pop_front();
               if (bus.mem_out_addr !== ea) begin
                  n_err++;
                  $display("FAIL read_addr: got %h, required %h", bus.mem_out_addr, ea);
               end
            end
         end
         if (bus.mem_out_valid === 1'b1) mem_valid_cycles++;
         if (bus.mem_out_valid === 1'b1 && !bus.mem_out_ready) mem_stall_cycles++;
         if (done === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (busy !== 1'b0) begin
               n_err++;
               $display("FAIL busy_at_done: busy=%b, required 0", busy);
            end
         end
         prev_stall     = bus.uart_in_valid && !bus.uart_in_ready;
         prev_data      = bus.uart_in_data;
         prev_mem_stall = bus.mem_out_valid && !bus.mem_out_ready;
         prev_addr      = bus.mem_out_addr;
      end else begin
         prev_stall     = 1'b0;
         prev_mem_stall = 1'b0;
      end
   end

   task automatic push_expect(input logic [31:0] base, input int cnt);
      logic [31:0] sum;
      logic [31:0] d;
      sum = '0;
      for (int w = 0; w < cnt; w++) begin
         exp_addrs.push_back(base + 32'(w));
         d = mem_word(base + 32'(w));
         sum = sum + d;
         for (int b = 3; b >= 0; b--) exp_bytes.push_back(8'(d >> (8 * b)));
      end
      for (int b = 3; b >= 0; b--) exp_bytes.push_back(8'(sum >> (8 * b)));
   endtask

   // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
   task automatic pulse_start(input logic [31:0] base, input int cnt);
      base_addr  = base;
      word_count = CW'(cnt);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_done(input int d0, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (done_cnt > d0) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b1;
      base_addr = 32'h10;
      word_count = CW'(2);
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
      n_vec++; if (bus.mem_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid: got %b, required 0", bus.mem_out_valid); end
      n_vec++; if (bus.mem_out_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h, required 0", bus.mem_out_addr); end
      n_vec++; if (bus.uart_in_valid !== 1'b0) begin n_err++; $display("FAIL rst_uvalid: got %b, required 0", bus.uart_in_valid); end
      n_vec++; if (bus.uart_in_data !== 8'h0) begin n_err++; $display("FAIL rst_udata: got %h, required 0", bus.uart_in_data); end
      start = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored: busy=%b, required 0", busy); end
      monitor_en = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] lit [12];
      int d0;
      bit to;
      lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h66, 8'h88, 8'hAA, 8'hCC};
      foreach (lit[i]) exp_bytes.push_back(lit[i]);
      exp_addrs.push_back(32'h10);
      exp_addrs.push_back(32'h11);
      d0 = done_cnt;
      pulse_start(32'h10, 2);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b, required 1", busy); end
      n_vec++; if (bus.mem_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_mvalid: got %b, required 1", bus.mem_out_valid); end
      n_vec++; if (bus.mem_out_addr !== 32'h10) begin n_err++; $display("FAIL basic_addr: got %h, required 00000010", bus.mem_out_addr); end
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (exp_bytes.size() != 0) begin n_err++; $display("FAIL basic_bytes_left: got %0d, required 0", exp_bytes.size()); end
      n_vec++; if (exp_addrs.size() != 0) begin n_err++; $display("FAIL basic_reads_left: got %0d, required 0", exp_addrs.size()); end
      n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d, required %0d", done_cnt - d0, 1); end
   endtask

   task automatic test_zero_count();
      int d0, m0;
      bit to;
      for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h00);
      d0 = done_cnt;
      m0 = mem_valid_cycles;
      pulse_start(32'h10, 0);
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL zero_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (mem_valid_cycles != m0) begin n_err++; $display("FAIL zero_reads: got %0d valid cycles, required 0", mem_valid_cycles - m0); end
      n_vec++; if (exp_bytes.size() != 0) begin n_err++; $display("FAIL zero_bytes_left: got %0d, required 0", exp_bytes.size()); end
      n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL zero_done_cnt: got %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_ready_throttle();
      int d0;
      bit to;
      ready_mode = 1;
      push_expect(32'h10, 2);
      d0 = done_cnt;
      pulse_start(32'h10, 2);
      wait_done(d0, to);
      ready_mode = 0;
      n_vec++; if (to) begin n_err++; $display("FAIL thr_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (exp_bytes.size() != 0) begin n_err++; $display("FAIL thr_bytes_left: got %0d, required 0", exp_bytes.size()); end
      n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL thr_done_cnt: got %0d, required 1", done_cnt - d0); end
   endtask

   task automatic test_mem_delay();
      int d0, s0;
      bit to;
      mem_delay = 5;
      push_expect(32'h20, 1);
      d0 = done_cnt;
      s0 = mem_stall_cycles;
      pulse_start(32'h20, 1);
      wait_done(d0, to);
      mem_delay = 0;
      n_vec++; if (to) begin n_err++; $display("FAIL dly_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (mem_stall_cycles - s0 != 5) begin n_err++; $display("FAIL dly_stall: got %0d cycles, required 5", mem_stall_cycles - s0); end
      n_vec++; if (exp_bytes.size() != 0 || exp_addrs.size() != 0) begin n_err++; $display("FAIL dly_left: got %0d/%0d, required 0/0", exp_bytes.size(), exp_addrs.size()); end
   endtask

   task automatic test_wrap();
      int d0;
      bit to;
      push_expect(32'hFFFF_FFFF, 2);
      d0 = done_cnt;
      pulse_start(32'hFFFF_FFFF, 2);
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL wrap_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (exp_bytes.size() != 0 || exp_addrs.size() != 0) begin n_err++; $display("FAIL wrap_left: got %0d/%0d, required 0/0", exp_bytes.size(), exp_addrs.size()); end
   endtask

   task automatic test_back_to_back();
      int d0;
      bit to;
      push_expect(32'h20, 1);
      d0 = done_cnt;
      pulse_start(32'h20, 1);
      repeat (2) @(posedge clk);
      #1;
      pulse_start(32'h10, 2);
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL b2b_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (done_cnt != d0 + 1) begin n_err++; $display("FAIL b2b_busy_start: got %0d done pulses, required 1", done_cnt - d0); end
      push_expect(32'h11, 1);
      d0 = done_cnt;
      pulse_start(32'h11, 1);
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL b2b2_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (exp_bytes.size() != 0 || exp_addrs.size() != 0) begin n_err++; $display("FAIL b2b_left: got %0d/%0d, required 0/0", exp_bytes.size(), exp_addrs.size()); end
   endtask

   task automatic test_abort();
      int d0, b0;
      bit to;
      push_expect(32'h10, 2);
      d0 = done_cnt;
      b0 = bytes_popped;
      stop_after = b0 + 2;
      ready_mode = 2;
      pulse_start(32'h10, 2);
      to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bytes_popped >= b0 + 2) begin
            to = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      n_vec++; if (to) begin n_err++; $display("FAIL abort_timeout: got %0d bytes, required 2", bytes_popped - b0); end
      // Second byte is taken at the next edge; reset one cycle later.
      @(posedge clk); #1;
      monitor_en = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, required 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b, required 0", done); end
      n_vec++; if (bus.mem_out_valid !== 1'b0 || bus.mem_out_addr !== 32'h0) begin n_err++; $display("FAIL abort_mem: got %b/%h, required 0/0", bus.mem_out_valid, bus.mem_out_addr); end
      n_vec++; if (bus.uart_in_valid !== 1'b0 || bus.uart_in_data !== 8'h0) begin n_err++; $display("FAIL abort_uart: got %b/%h, required 0/00", bus.uart_in_valid, bus.uart_in_data); end
      reset = 1'b1;
      ready_mode = 0;
      exp_bytes.delete();
      exp_addrs.delete();
      @(posedge clk); #1;
      monitor_en = 1'b1;
      n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0); end
      push_expect(32'h20, 1);
      d0 = done_cnt;
      pulse_start(32'h20, 1);
      wait_done(d0, to);
      n_vec++; if (to) begin n_err++; $display("FAIL abort_restart_timeout: done not seen, required within 3000 cycles"); end
      n_vec++; if (exp_bytes.size() != 0 || exp_addrs.size() != 0) begin n_err++; $display("FAIL abort_restart_left: got %0d/%0d, required 0/0", exp_bytes.size(), exp_addrs.size()); end
   endtask

   initial begin
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      test_reset();
      test_basic();
      test_zero_count();
      test_ready_throttle();
      test_mem_delay();
      test_wrap();
      test_back_to_back();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
